score_keeper: RTL and testbench

SCORE_KEEPER -- requirements
Module: score_keeper

---
 rtl/score_keeper.sv | 165 ++++++++++++++++
 tb/tb_score_keeper.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/score_keeper.sv
// Whack-a-mole score keeper: edge-detected hit/miss scoring with streak
// bonus, saturating score, high-score tracking and a registered display value.
module score_keeper #(
  parameter logic [10:0] MAX_SCORE = 11'd1999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        hit,
  input  logic        miss,
  input  logic        game_over,
  output logic [10:0] value,
  output logic        playing,
  output logic        new_record,
  output logic        update
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PLAYING   = 2'd1,
    GAME_OVER = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [10:0] score_q, score_d;
  logic [3:0]  streak_q, streak_d;
  logic [10:0] high_q, high_d;
  logic        new_rec_q, new_rec_d;
  logic [10:0] value_q, value_d;
  logic        update_q, update_d;

  logic start_q, hit_q, miss_q, go_q;
  logic armed_q;

  logic start_e, hit_e, miss_e, go_e;

  // Edges are only recognised once a post-reset sample exists,
  // so an input already high at reset release never counts.
  assign start_e = armed_q & start & ~start_q;
  assign hit_e   = armed_q & hit & ~hit_q;
  assign miss_e  = armed_q & miss & ~miss_q;
  assign go_e    = armed_q & game_over & ~go_q;

  logic [1:0]  pts;
  logic [11:0] sum;
  logic [10:0] hit_score;
  logic [10:0] play_score;
  logic [3:0]  play_streak;

  always_comb begin
    pts = 2'd1;
    unique case (1'b1)
      (streak_q >= 4'd10):                pts = 2'd3;
      (streak_q >= 4'd5) &&
      (streak_q < 4'd10):                 pts = 2'd2;
      (streak_q < 4'd5):                  pts = 2'd1;
    endcase
  end

  always_comb begin
    sum = {1'b0, score_q} + {10'd0, pts};
    hit_score = sum[10:0];
    if (sum > {1'b0, MAX_SCORE}) begin
      hit_score = MAX_SCORE;
    end
  end

  // Miss wins over a coincident hit.
  always_comb begin
    play_score  = score_q;
    play_streak = streak_q;
    if (miss_e) begin
      play_streak = 4'd0;
      if (score_q != 11'd0) begin
        play_score = score_q - 11'd1;
      end
    end else if (hit_e) begin
      play_score = hit_score;
      if (streak_q != 4'd15) begin
        play_streak = streak_q + 4'd1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    score_d   = score_q;
    streak_d  = streak_q;
    high_d    = high_q;
    new_rec_d = new_rec_q;
    unique case (state_q)
      IDLE: begin
        if (start_e) begin
          state_d   = PLAYING;
          score_d   = 11'd0;
          streak_d  = 4'd0;
          new_rec_d = 1'b0;
        end
      end
      PLAYING: begin
        score_d  = play_score;
        streak_d = play_streak;
        if (go_e) begin
          state_d = GAME_OVER;
          if (play_score > high_q) begin
            high_d    = play_score;
            new_rec_d = 1'b1;
          end
        end
      end
      GAME_OVER: begin
        if (start_e) begin
          state_d   = PLAYING;
          score_d   = 11'd0;
          streak_d  = 4'd0;
          new_rec_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    value_d  = (state_q == IDLE) ? high_q : score_q;
    update_d = (value_d != value_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      score_q   <= 11'd0;
      streak_q  <= 4'd0;
      high_q    <= 11'd0;
      new_rec_q <= 1'b0;
      value_q   <= 11'd0;
      update_q  <= 1'b0;
      start_q   <= 1'b0;
      hit_q     <= 1'b0;
      miss_q    <= 1'b0;
      go_q      <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      score_q   <= score_d;
      streak_q  <= streak_d;
      high_q    <= high_d;
      new_rec_q <= new_rec_d;
      value_q   <= value_d;
      update_q  <= update_d;
      start_q   <= start;
      hit_q     <= hit;
      miss_q    <= miss;
      go_q      <= game_over;
      armed_q   <= 1'b1;
    end
  end

  assign value      = value_q;
  assign playing    = (state_q == PLAYING);
  assign new_record = new_rec_q;
  assign update     = update_q;

endmodule

// File: tb/tb_score_keeper.sv
// Scoreboard bench for score_keeper: expected display values are queued
// by the stimulus and consumed by a monitor on every update pulse.
module tb_score_keeper;

  logic        clk;
  logic        rst;
  logic        start;
  logic        hit;
  logic        miss;
  logic        game_over;
  logic [10:0] value;
  logic        playing;
  logic        new_record;
  logic        update;

  int n_pass;
  int n_total;
  int exp_q[$];

  score_keeper #(.MAX_SCORE(11'd1999)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .hit        (hit),
    .miss       (miss),
    .game_over  (game_over),
    .value      (value),
    .playing    (playing),
    .new_record (new_record),
    .update     (update)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Monitor: every update pulse must match the oldest expected value.
  always @(negedge clk) begin
    if (rst && update) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_update: got value %0d expected no update",
                 value);
      end else begin
        chk("update_value", int'(value), exp_q.pop_front());
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 12) begin
      tick(1);
      k++;
    end
    tick(3);
    chk(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    chk("rst_value", int'(value), 0);
    chk("rst_update", int'(update), 0);
    chk("rst_playing", int'(playing), 0);
    tick(2);
    rst = 1'b1;
    tick(2);
  endtask

  task automatic p_start();
    start = 1'b1; tick(1); start = 1'b0; tick(1);
  endtask

  task automatic p_hit(input int e);
    exp_q.push_back(e);
    hit = 1'b1; tick(1); hit = 1'b0; tick(1);
  endtask

  task automatic p_miss();
    miss = 1'b1; tick(1); miss = 1'b0; tick(1);
  endtask

  task automatic p_go();
    game_over = 1'b1; tick(1); game_over = 1'b0; tick(1);
  endtask

  initial begin
    int e;
    int seq12[12];
    n_pass = 0;
    n_total = 0;
    rst = 1'b1;
    start = 1'b0;
    hit = 1'b0;
    miss = 1'b0;
    game_over = 1'b0;
    #1;
    do_reset();
    chk("idle_value", int'(value), 0);
    chk("idle_playing", int'(playing), 0);
    chk("idle_update", int'(update), 0);
    chk("idle_new_record", int'(new_record), 0);

    // Twelve hits: 5x1 + 5x2 + 2x3 = 21
    seq12 = '{1, 2, 3, 4, 5, 7, 9, 11, 13, 15, 18, 21};
    p_start();
    chk("start_playing", int'(playing), 1);
    foreach (seq12[i]) p_hit(seq12[i]);
    drain("hits12_drain");
    chk("hits12_value", int'(value), 21);

    // Miss floor, streak reset, hit+miss coincidence
    do_reset();
    p_start();
    p_miss();
    tick(3);
    chk("miss_floor", int'(value), 0);
    p_hit(1); p_hit(2); p_hit(3); p_hit(4); p_hit(5); p_hit(7);
    drain("hits6_drain");
    chk("hits6_value", int'(value), 7);
    exp_q.push_back(6);
    hit = 1'b1; miss = 1'b1; tick(1);
    hit = 1'b0; miss = 1'b0; tick(1);
    p_hit(7);
    drain("hitmiss_drain");
    chk("after_hitmiss", int'(value), 7);

    // Game over at 9, record, tie, beat, abort
    do_reset();
    p_start();
    for (int i = 1; i <= 5; i++) p_hit(i);
    p_hit(7); p_hit(9);
    p_go();
    drain("go9_drain");
    chk("go9_playing", int'(playing), 0);
    chk("go9_record", int'(new_record), 1);
    chk("go9_value", int'(value), 9);
    p_hit(10);
    void'(exp_q.pop_back());
    tick(3);
    chk("go_hit_ignored", int'(value), 9);
    exp_q.push_back(0);
    p_start();
    drain("restart_drain");
    chk("restart_value", int'(value), 0);
    chk("restart_record", int'(new_record), 0);
    for (int i = 1; i <= 5; i++) p_hit(i);
    p_hit(7);
    exp_q.push_back(9);
    hit = 1'b1; game_over = 1'b1; tick(1);
    hit = 1'b0; game_over = 1'b0; tick(1);
    drain("tie_drain");
    chk("tie_record", int'(new_record), 0);
    chk("tie_playing", int'(playing), 0);
    exp_q.push_back(0);
    p_start();
    for (int i = 1; i <= 5; i++) p_hit(i);
    p_hit(7); p_hit(9); p_hit(11);
    p_go();
    drain("beat_drain");
    chk("beat_record", int'(new_record), 1);
    exp_q.push_back(0);
    p_start();
    p_hit(1); p_hit(2);
    drain("abort_drain");
    do_reset();
    p_go();
    tick(3);
    chk("abort_high", int'(value), 0);
    chk("abort_playing", int'(playing), 0);

    // Held hit counts once; start in PLAYING ignored
    p_start();
    exp_q.push_back(1);
    hit = 1'b1; tick(20); hit = 1'b0; tick(2);
    p_start();
    drain("held_drain");
    chk("held_value", int'(value), 1);
    chk("held_playing", int'(playing), 1);

    // Inputs high at reset release are not edges
    rst = 1'b0;
    start = 1'b1;
    hit = 1'b1;
    tick(2);
    rst = 1'b1;
    tick(4);
    chk("rel_high_playing", int'(playing), 0);
    start = 1'b0;
    hit = 1'b0;
    tick(2);
    chk("rel_high_value", int'(value), 0);

    // Saturation at 1999
    p_start();
    for (int i = 1; i <= 672; i++) begin
      if (i <= 5) e = i;
      else if (i <= 10) e = 5 + 2 * (i - 5);
      else e = 15 + 3 * (i - 10);
      if (e > 1999) e = 1999;
      p_hit(e);
    end
    drain("clamp_drain");
    chk("clamp_value", int'(value), 1999);
    hit = 1'b1; tick(1); hit = 1'b0; tick(4);
    chk("clamp_extra", int'(value), 1999);
    drain("final_drain");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
